dadder_bcd_pipe: RTL and testbench

- Pipelined, parametrised decimal (BCD) adder/subtracter and successor to the single-stage decimal adder data plane.
- Generalised to NUM_DIGITS digits, split across NUM_DIGITS/DIGITS_PER_STAGE register stages with carry-skewed operands.
- Adds a per-transaction add/sub mode, invalid-digit detection, and valid/ready handshakes with backpressure on both sides.
- Sits between the data plane input agent boundary and the result consumer; throughput is 1 operation/cycle.

---
 rtl/dadder_bcd_pipe_pkg.sv | 35 +++
 rtl/dadder_bcd_pipe_if.sv | 33 +++
 rtl/dadder_bcd_pipe_stage.sv | 84 ++++++++
 rtl/dadder_bcd_pipe.sv | 73 +++++++
 tb/tb_dadder_bcd_pipe.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dadder_bcd_pipe_pkg.sv
// Shared types and digit helpers for the pipelined BCD adder.
// No ports: BCD digit type, add/sub mode enum, one-digit add and nines-complement helpers.
package dadder_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    DADDER_ADD = 1'b0,
    DADDER_SUB = 1'b1
  } dadder_mode_e;

  // Returns {cout, digit}. Invalid inputs wrap mod 16.
  function automatic logic [4:0] bcd_digit_add(
    input bcd_digit_t a,
    input bcd_digit_t b,
    input logic       cin
  );
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (s > 5'd9) begin
      bcd_digit_add = {1'b1, s[3:0] + 4'd6};
    end else begin
      bcd_digit_add = {1'b0, s[3:0]};
    end
  endfunction

  function automatic bcd_digit_t bcd_nines(input bcd_digit_t d);
    bcd_nines = 4'd9 - d;
  endfunction

  function automatic logic bcd_bad(input bcd_digit_t d);
    bcd_bad = (d > 4'd9);
  endfunction

endpackage

// File: rtl/dadder_bcd_pipe_if.sv
// Valid/ready bus of the BCD adder: operation in, result out.
// slave = adder side, master = producer/consumer side.
interface dadder_bcd_pipe_if #(
  parameter int NUM_DIGITS = 8
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic                    in_carry;
  logic [4*NUM_DIGITS-1:0] in_op_a;
  logic [4*NUM_DIGITS-1:0] in_op_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] out_result;
  logic                    out_carry;
  logic                    out_error;

  modport slave (
    input  in_valid, in_mode, in_carry,
    input  in_op_a, in_op_b, out_ready,
    output in_ready, out_valid,
    output out_result, out_carry, out_error
  );

  modport master (
    output in_valid, in_mode, in_carry,
    output in_op_a, in_op_b, out_ready,
    input  in_ready, out_valid,
    input  out_result, out_carry, out_error
  );

endinterface

// File: rtl/dadder_bcd_pipe_stage.sv
// One pipeline stage: ripples its digit slice and registers the operation forward.
// Ports: clk, reset, en (global advance), in_* from previous stage, out_* registered.
module dadder_bcd_stage
  import dadder_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DPS        = 2,
  parameter int IDX        = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    in_valid,
  input  dadder_mode_e            in_mode,
  input  logic                    in_err,
  input  logic                    in_carry,
  input  logic [4*NUM_DIGITS-1:0] in_a,
  input  logic [4*NUM_DIGITS-1:0] in_b,
  output logic                    out_valid,
  output dadder_mode_e            out_mode,
  output logic                    out_err,
  output logic                    out_carry,
  output logic [4*NUM_DIGITS-1:0] out_a,
  output logic [4*NUM_DIGITS-1:0] out_b
);

  logic [4*NUM_DIGITS-1:0] b_eff;
  logic [4*NUM_DIGITS-1:0] a_nxt;
  logic                    err_nxt;
  logic                    c_nxt;

  // Stage 0 complements B and checks digits; later stages see B' already.
  if (IDX == 0) begin : g_first
    always_comb begin
      b_eff   = in_b;
      err_nxt = in_err;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (in_mode == DADDER_SUB) begin
          b_eff[4*i +: 4] = bcd_nines(in_b[4*i +: 4]);
        end
        err_nxt = err_nxt
                | bcd_bad(in_a[4*i +: 4])
                | bcd_bad(in_b[4*i +: 4]);
      end
    end
  end else begin : g_rest
    assign b_eff   = in_b;
    assign err_nxt = in_err;
  end

  // Low digits already resolved and high digits of A pass through untouched.
  always_comb begin
    logic [4:0] r;
    r     = '0;
    a_nxt = in_a;
    c_nxt = in_carry;
    for (int j = 0; j < DPS; j++) begin
      r = bcd_digit_add(in_a[4*(IDX*DPS+j) +: 4],
                        b_eff[4*(IDX*DPS+j) +: 4],
                        c_nxt);
      a_nxt[4*(IDX*DPS+j) +: 4] = r[3:0];
      c_nxt = r[4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mode  <= DADDER_ADD;
      out_err   <= 1'b0;
      out_carry <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_err   <= err_nxt;
      out_carry <= c_nxt;
      out_a     <= a_nxt;
      out_b     <= b_eff;
    end
  end

endmodule

// File: rtl/dadder_bcd_pipe.sv
// Pipelined NUM_DIGITS BCD adder/subtracter, DIGITS_PER_STAGE digits per stage.
// Ports: clk, reset (sync, active-high), bus (slave side of dadder_bcd_pipe_if).
module dadder_bcd_pipe
  import dadder_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int DIGITS_PER_STAGE = 2
) (
  input logic               clk,
  input logic               reset,
  dadder_bcd_pipe_if.slave  bus
);

  localparam int STAGES = NUM_DIGITS / DIGITS_PER_STAGE;
  localparam int W      = 4 * NUM_DIGITS;

  if (NUM_DIGITS % DIGITS_PER_STAGE != 0) begin : g_bad_cfg
    $error("NUM_DIGITS must be a multiple of DIGITS_PER_STAGE");
  end

  logic         adv;
  logic         v_p [STAGES+1];
  dadder_mode_e m_p [STAGES+1];
  logic         e_p [STAGES+1];
  logic         c_p [STAGES+1];
  logic [W-1:0] a_p [STAGES+1];
  logic [W-1:0] b_p [STAGES+1];
  logic         unused_tail;

  // Whole pipe moves together; only a blocked result stalls it.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  assign v_p[0] = bus.in_valid;
  assign m_p[0] = dadder_mode_e'(bus.in_mode);
  assign e_p[0] = 1'b0;
  assign c_p[0] = bus.in_carry;
  assign a_p[0] = bus.in_op_a;
  assign b_p[0] = bus.in_op_b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    dadder_bcd_stage #(
      .NUM_DIGITS (NUM_DIGITS),
      .DPS        (DIGITS_PER_STAGE),
      .IDX        (k)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (adv),
      .in_valid  (v_p[k]),
      .in_mode   (m_p[k]),
      .in_err    (e_p[k]),
      .in_carry  (c_p[k]),
      .in_a      (a_p[k]),
      .in_b      (b_p[k]),
      .out_valid (v_p[k+1]),
      .out_mode  (m_p[k+1]),
      .out_err   (e_p[k+1]),
      .out_carry (c_p[k+1]),
      .out_a     (a_p[k+1]),
      .out_b     (b_p[k+1])
    );
  end

  assign bus.out_valid  = v_p[STAGES];
  assign bus.out_result = a_p[STAGES];
  assign bus.out_carry  = c_p[STAGES];
  assign bus.out_error  = e_p[STAGES];

  // Mode and B' are fully consumed by the last stage.
  assign unused_tail = ^{m_p[STAGES], b_p[STAGES]};

endmodule

// File: tb/tb_dadder_bcd_pipe.sv
// Directed self-checking bench for dadder_bcd_pipe (8 digits, 2 per stage).
// Drives the bus interface, compares against hand-computed BCD results.
module tb_dadder_bcd_pipe;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  dadder_bcd_pipe_if #(.NUM_DIGITS(8)) bus ();

  dadder_bcd_pipe #(
    .NUM_DIGITS       (8),
    .DIGITS_PER_STAGE (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input string       name,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        mode,
    input logic        cin,
    input logic [31:0] exp_r,
    input logic        exp_c,
    input logic        exp_e
  );
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_carry  = cin;
    bus.in_op_a   = a;
    bus.in_op_b   = b;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s in_ready got %b want 1", name, bus.in_ready);
    end
    step;
    bus.in_valid = 1'b0;
    bus.in_op_a  = 32'hFFFF_FFFF;
    bus.in_op_b  = 32'hFFFF_FFFF;
    lat = 1;
    while (!bus.out_valid && lat < 16) begin
      step;
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL %s latency got %0d want 4", name, lat);
    end
    checks++;
    if (bus.out_result !== exp_r) begin
      fails++;
      $display("FAIL %s result got %h want %h", name, bus.out_result, exp_r);
    end
    checks++;
    if (bus.out_carry !== exp_c) begin
      fails++;
      $display("FAIL %s carry got %b want %b", name, bus.out_carry, exp_c);
    end
    checks++;
    if (bus.out_error !== exp_e) begin
      fails++;
      $display("FAIL %s error got %b want %b", name, bus.out_error, exp_e);
    end
    step;
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_carry  = 1'b0;
    bus.in_op_a   = '0;
    bus.in_op_b   = '0;
    bus.out_ready = 1'b0;
    step;
    step;
    checks++;
    if ({bus.out_valid, bus.out_carry, bus.out_error} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got %b%b%b want 000",
               bus.out_valid, bus.out_carry, bus.out_error);
    end
    checks++;
    if (bus.out_result !== 32'h0) begin
      fails++;
      $display("FAIL reset_result got %h want 0", bus.out_result);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    step;
  endtask

  task automatic test_add;
    run_op("add_carry", 32'h19, 32'h01, 1'b0, 1'b0, 32'h20, 1'b0, 1'b0);
    run_op("ripple_b1", 32'h9999_9999, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_op("ripple_cin", 32'h9999_9999, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_sub;
    run_op("sub_pos", 32'h100, 32'h1, 1'b1, 1'b1, 32'h99, 1'b1, 1'b0);
    run_op("sub_neg", 32'h1, 32'h2, 1'b1, 1'b1, 32'h9999_9999, 1'b0, 1'b0);
  endtask

  task automatic test_invalid;
    run_op("bad_digit", 32'hA, 32'h0, 1'b0, 1'b0, 32'h10, 1'b0, 1'b1);
    run_op("after_bad", 32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int n;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 1'b0;
    bus.in_carry  = 1'b0;
    bus.in_op_a   = 32'h25;
    bus.in_op_b   = 32'h17;
    step;
    bus.in_mode   = 1'b1;
    bus.in_carry  = 1'b1;
    bus.in_op_a   = 32'h50;
    bus.in_op_b   = 32'h25;
    step;
    bus.in_valid  = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 16) begin
      step;
      n++;
    end
    checks++;
    if ({bus.out_valid, bus.out_carry, bus.out_result} !== {2'b10, 32'h42}) begin
      fails++;
      $display("FAIL b2b_add got v%b c%b %h want v1 c0 00000042",
               bus.out_valid, bus.out_carry, bus.out_result);
    end
    step;
    checks++;
    if ({bus.out_valid, bus.out_carry, bus.out_result} !== {2'b11, 32'h25}) begin
      fails++;
      $display("FAIL b2b_sub got v%b c%b %h want v1 c1 00000025",
               bus.out_valid, bus.out_carry, bus.out_result);
    end
    step;
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_r [6];
    logic [31:0] prev_r;
    logic        stalled;
    int          sent;
    int          recv;
    exp_r   = '{32'h02, 32'h04, 32'h06, 32'h08, 32'h10, 32'h12};
    sent    = 0;
    recv    = 0;
    stalled = 1'b0;
    prev_r  = '0;
    bus.in_mode  = 1'b0;
    bus.in_carry = 1'b0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      bus.out_ready = !(c >= 3 && c <= 8);
      bus.in_valid  = (sent < 6);
      bus.in_op_a   = 32'(sent + 1);
      bus.in_op_b   = 32'(sent + 1);
      #1;
      if (stalled) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== prev_r) begin
          fails++;
          $display("FAIL bp_hold got v%b %h want v1 %h",
                   bus.out_valid, bus.out_result, prev_r);
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL bp_in_ready got %b want 0", bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_result !== exp_r[recv]) begin
          fails++;
          $display("FAIL bp_result[%0d] got %h want %h",
                   recv, bus.out_result, exp_r[recv]);
        end
        recv++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      prev_r  = bus.out_result;
      if (bus.in_valid && bus.in_ready) sent++;
      step;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (recv !== 6) begin
      fails++;
      $display("FAIL bp_count got %0d want 6", recv);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_no_dup out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midflight;
    bus.out_ready = 1'b1;
    bus.in_mode   = 1'b0;
    bus.in_carry  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op_a  = 32'(k + 3);
      bus.in_op_b  = 32'h1;
      step;
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid got v%b rdy%b want v0 rdy1",
               bus.out_valid, bus.in_ready);
    end
    for (int k = 0; k < 6; k++) begin
      step;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_stale cycle %0d out_valid got %b want 0",
                 k, bus.out_valid);
      end
    end
    run_op("post_reset", 32'h48, 32'h37, 1'b0, 1'b0, 32'h85, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_invalid();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
